// File: rtl/compress_pkg.sv
// compress_pkg: shared block geometry, frame limits and scheduler state encoding
package compress_pkg;
  localparam int BLOCK_SIZE = 8;
  localparam int MAX_BLK_X = 80;
  localparam int MAX_BLK_Y = 60;
  typedef enum logic [2:0] {IDLE, FETCH, START, WAIT, OUT, DONE} sched_state_t;
endpackage

// File: rtl/block_raster_cnt.sv
// block_raster_cnt: raster-order block x/y counter with load, increment and last-block flag
module block_raster_cnt #(
  parameter int XW = 7,
  parameter int YW = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [XW:0]   cnt_x,
  input  logic [YW:0]   cnt_y,
  input  logic          inc,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last
);
  logic [XW:0] mx;
  logic [YW:0] my;
  logic        x_end;
  assign x_end = ({1'b0, x} + (XW+1)'(1)) == mx;
  assign last  = x_end && (({1'b0, y} + (YW+1)'(1)) == my);
  // Counts are latched once per frame; advancing stops at the final block.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mx <= '0;
      my <= '0;
      x  <= '0;
      y  <= '0;
    end else if (load) begin
      mx <= cnt_x;
      my <= cnt_y;
      x  <= '0;
      y  <= '0;
    end else if (inc && !last) begin
      x <= x_end ? '0 : x + 1'b1;
      y <= x_end ? y + 1'b1 : y;
    end
  end
endmodule

// File: rtl/compress_scheduler.sv
// compress_scheduler: frame block sequencer (fetch, start, wait, hand off); COMPRESS_SCHED_PERF_EN adds perf_stall_cyc
module compress_scheduler
  import compress_pkg::*;
#(
  parameter int MAX_BLK_X = compress_pkg::MAX_BLK_X,
  parameter int MAX_BLK_Y = compress_pkg::MAX_BLK_Y,
  localparam int XW = $clog2(MAX_BLK_X),
  localparam int YW = $clog2(MAX_BLK_Y)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_start,
  input  logic [XW:0]   cfg_blk_x,
  input  logic [YW:0]   cfg_blk_y,
  output logic          fetch_req,
  input  logic          fetch_ack,
  output logic [XW-1:0] blk_x,
  output logic [YW-1:0] blk_y,
  output logic          start_block,
  input  logic          block_done,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic          busy,
  output logic          frame_done
`ifdef COMPRESS_SCHED_PERF_EN
  ,
  output logic [31:0]   perf_stall_cyc
`endif
);
  sched_state_t st, nxt;
  logic [XW:0] cx;
  logic [YW:0] cy;
  logic        load, inc, last;
  assign cx = (cfg_blk_x > (XW+1)'(MAX_BLK_X)) ? (XW+1)'(MAX_BLK_X) : cfg_blk_x;
  assign cy = (cfg_blk_y > (YW+1)'(MAX_BLK_Y)) ? (YW+1)'(MAX_BLK_Y) : cfg_blk_y;
  assign load = (st == IDLE) && frame_start;
  assign inc  = (st == OUT) && out_ready;
  block_raster_cnt #(.XW(XW), .YW(YW)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load),
    .cnt_x (cx),
    .cnt_y (cy),
    .inc   (inc),
    .x     (blk_x),
    .y     (blk_y),
    .last  (last)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= nxt;
  end
  always_comb begin
    nxt = st;
    unique case (st)
      IDLE:    if (frame_start) nxt = (cx == '0 || cy == '0) ? DONE : FETCH;
      FETCH:   if (fetch_ack) nxt = START;
      START:   nxt = WAIT;
      WAIT:    if (block_done) nxt = OUT;
      OUT:     if (out_ready) nxt = last ? DONE : FETCH;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  assign fetch_req   = st == FETCH;
  assign start_block = st == START;
  assign out_valid   = st == OUT;
  assign out_last    = out_valid && last;
  assign busy        = st != IDLE;
  assign frame_done  = st == DONE;
`ifdef COMPRESS_SCHED_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                             perf_stall_cyc <= '0;
    else if (load)                                          perf_stall_cyc <= '0;
    else if (out_valid && !out_ready && perf_stall_cyc != '1) perf_stall_cyc <= perf_stall_cyc + 1'b1;
  end
`endif
endmodule
